// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the in-order writeback and a FIFO-buffered
// long-latency return path. Optional macro WB_BYPASS_EN lets results skip an empty idle FIFO.
module wb_port_arbiter #(
    parameter int unsigned DATA_W       = 24,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_valid,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      pipe_stall,
    input  logic                      ll_valid,
    output logic                      ll_ready,
    input  logic [ADDR_W-1:0]         ll_addr,
    input  logic [DATA_W-1:0]         ll_data,
    output logic [$clog2(DEPTH):0]    ll_pending,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      rf_src
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ST_W-1:0]  LIMIT_C = ST_W'(STARVE_LIMIT);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ST_W-1:0]  starve_q, starve_d;

    logic              not_empty;
    logic              force_ll;
    logic              grant_pipe;
    logic              grant_ll;
    logic              bypass;
    logic              enq;
    logic              deq;
    logic              rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_d;
    logic              rf_src_d;

    assign not_empty  = (count_q != '0);
    assign ll_ready   = (count_q < DEPTH_C);
    assign ll_pending = count_q;

    assign force_ll   = not_empty & (starve_q == LIMIT_C);
    assign grant_pipe = wb_valid & ~force_ll;
    assign grant_ll   = not_empty & ~grant_pipe;
    assign pipe_stall = wb_valid & force_ll;

`ifdef WB_BYPASS_EN
    // An idle port with an empty FIFO writes the offered result straight through.
    assign bypass = ~wb_valid & ll_valid & ~not_empty;
`else
    assign bypass = 1'b0;
`endif

    assign enq = ll_valid & ll_ready & ~bypass;
    assign deq = grant_ll;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (!enq && deq) begin
            count_d = count_q - 1'b1;
        end

        if (!not_empty || grant_ll) begin
            starve_d = '0;
        end else if (starve_q != LIMIT_C) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        rf_we_d    = grant_pipe | grant_ll | bypass;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
        rf_src_d   = rf_src;

        if (grant_pipe) begin
            rf_waddr_d = wb_addr;
            rf_wdata_d = wb_data;
            rf_src_d   = 1'b0;
        end else if (grant_ll) begin
            rf_waddr_d = addr_mem[rd_ptr_q];
            rf_wdata_d = data_mem[rd_ptr_q];
            rf_src_d   = 1'b1;
        end else if (bypass) begin
            rf_waddr_d = ll_addr;
            rf_wdata_d = ll_data;
            rf_src_d   = 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_q] <= ll_addr;
            data_mem[wr_ptr_q] <= ll_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_src   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            rf_we    <= rf_we_d;
            rf_waddr <= rf_waddr_d;
            rf_wdata <= rf_wdata_d;
            rf_src   <= rf_src_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=3); works with or without
// WB_BYPASS_EN.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [23:0] wb_data;
    logic        pipe_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [3:0]  ll_addr;
    logic [23:0] ll_data;
    logic [1:0]  ll_pending;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [23:0] rf_wdata;
    logic        rf_src;

    int vectors = 0;
    int misc    = 0;

    wb_port_arbiter #(
        .DATA_W      (24),
        .ADDR_W      (4),
        .DEPTH       (2),
        .STARVE_LIMIT(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .pipe_stall(pipe_stall),
        .ll_valid  (ll_valid),
        .ll_ready  (ll_ready),
        .ll_addr   (ll_addr),
        .ll_data   (ll_data),
        .ll_pending(ll_pending),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_src    (rf_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            misc++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [3:0] a, input logic [23:0] d,
                          input logic s);
        chk({tag, ".we"}, 32'(rf_we), 32'd1);
        chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
        chk({tag, ".data"}, 32'(rf_wdata), 32'(d));
        chk({tag, ".src"}, 32'(rf_src), 32'(s));
    endtask

    task automatic offer_ll(input logic [3:0] a, input logic [23:0] d);
        ll_valid = 1'b1;
        ll_addr  = a;
        ll_data  = d;
    endtask

    task automatic drive_wb(input logic [3:0] a, input logic [23:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
    endtask

    initial begin
        rst      = 1'b1;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        ll_valid = 1'b0;
        ll_addr  = '0;
        ll_data  = '0;
        tick();
        tick();
        chk("rst.we", 32'(rf_we), 32'd0);
        chk("rst.addr", 32'(rf_waddr), 32'd0);
        chk("rst.data", 32'(rf_wdata), 32'd0);
        chk("rst.src", 32'(rf_src), 32'd0);
        chk("rst.pending", 32'(ll_pending), 32'd0);
        chk("rst.ready", 32'(ll_ready), 32'd1);
        chk("rst.stall", 32'(pipe_stall), 32'd0);
        rst = 1'b0;
        tick();

        // Pipeline-only write.
        drive_wb(4'd5, 24'h00ABCD);
        #1;
        chk("wb.stall", 32'(pipe_stall), 32'd0);
        tick();
        chk_wr("wb", 4'd5, 24'h00ABCD, 1'b0);
        wb_valid = 1'b0;
        tick();
        chk("wb.idle_we", 32'(rf_we), 32'd0);
        chk("wb.hold_addr", 32'(rf_waddr), 32'd5);

        // Long-latency write into an idle port.
        offer_ll(4'd3, 24'h123456);
        #1;
        chk("ll.ready", 32'(ll_ready), 32'd1);
        tick();
        ll_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk_wr("ll_bypass", 4'd3, 24'h123456, 1'b1);
        chk("ll.pending", 32'(ll_pending), 32'd0);
        tick();
        chk("ll.after_we", 32'(rf_we), 32'd0);
`else
        chk("ll.early_we", 32'(rf_we), 32'd0);
        chk("ll.pending1", 32'(ll_pending), 32'd1);
        tick();
        chk_wr("ll_fifo", 4'd3, 24'h123456, 1'b1);
        chk("ll.pending0", 32'(ll_pending), 32'd0);
`endif
        tick();
        chk("ll.idle_we", 32'(rf_we), 32'd0);

        // Fill the FIFO while the pipeline writes every cycle.
        drive_wb(4'd1, 24'h000111);
        offer_ll(4'd7, 24'h0000A1);
        tick();
        chk_wr("fill.a", 4'd1, 24'h000111, 1'b0);
        chk("fill.pend1", 32'(ll_pending), 32'd1);
        offer_ll(4'd8, 24'h0000A2);
        #1;
        chk("fill.ready1", 32'(ll_ready), 32'd1);
        tick();
        offer_ll(4'd9, 24'h0000A3);
        #1;
        chk("fill.ready0", 32'(ll_ready), 32'd0);
        chk("fill.pend2", 32'(ll_pending), 32'd2);
        chk("fill.stall_c", 32'(pipe_stall), 32'd0);
        tick();
        chk("fill.held_pend", 32'(ll_pending), 32'd2);
        chk("fill.src_c", 32'(rf_src), 32'd0);
        chk("fill.stall_d", 32'(pipe_stall), 32'd0);
        tick();
        chk("fill.stall_e", 32'(pipe_stall), 32'd1);
        chk("fill.ready_e", 32'(ll_ready), 32'd0);
        tick();
        chk_wr("fill.forced", 4'd7, 24'h0000A1, 1'b1);
        chk("fill.pend_e", 32'(ll_pending), 32'd1);
        #1;
        chk("fill.ready_f", 32'(ll_ready), 32'd1);
        chk("fill.stall_f", 32'(pipe_stall), 32'd0);
        tick();
        chk_wr("fill.resume", 4'd1, 24'h000111, 1'b0);
        chk("fill.pend_f", 32'(ll_pending), 32'd2);
        wb_valid = 1'b0;
        ll_valid = 1'b0;
        tick();
        chk_wr("fill.drain2", 4'd8, 24'h0000A2, 1'b1);
        tick();
        chk_wr("fill.drain3", 4'd9, 24'h0000A3, 1'b1);
        chk("fill.pend_end", 32'(ll_pending), 32'd0);
        tick();
        chk("fill.idle_we", 32'(rf_we), 32'd0);

        // Starvation: one entry queued behind continuous pipeline writes.
        drive_wb(4'd2, 24'h000222);
        offer_ll(4'd4, 24'h0000B4);
        tick();
        ll_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("starve.no_stall", 32'(pipe_stall), 32'd0);
            tick();
            chk("starve.pipe_src", 32'(rf_src), 32'd0);
        end
        chk("starve.stall", 32'(pipe_stall), 32'd1);
        tick();
        chk_wr("starve.forced", 4'd4, 24'h0000B4, 1'b1);
        chk("starve.pend", 32'(ll_pending), 32'd0);
        chk("starve.released", 32'(pipe_stall), 32'd0);
        tick();
        chk_wr("starve.resume", 4'd2, 24'h000222, 1'b0);
        wb_valid = 1'b0;
        tick();
        chk("starve.once", 32'(rf_we), 32'd0);

        // Simultaneous enqueue and dequeue at count=1.
        drive_wb(4'd6, 24'h000666);
        offer_ll(4'd10, 24'h0000C1);
        tick();
        wb_valid = 1'b0;
        offer_ll(4'd11, 24'h0000C2);
        #1;
        chk("eqdq.ready", 32'(ll_ready), 32'd1);
        tick();
        chk("eqdq.pend", 32'(ll_pending), 32'd1);
        chk_wr("eqdq.first", 4'd10, 24'h0000C1, 1'b1);
        ll_valid = 1'b0;
        tick();
        chk_wr("eqdq.second", 4'd11, 24'h0000C2, 1'b1);
        chk("eqdq.pend0", 32'(ll_pending), 32'd0);
        tick();

        // Mid-operation asynchronous reset with two entries queued.
        drive_wb(4'd6, 24'h000777);
        offer_ll(4'd12, 24'h0000D1);
        tick();
        offer_ll(4'd13, 24'h0000D2);
        tick();
        ll_valid = 1'b0;
        chk("mrst.pend_pre", 32'(ll_pending), 32'd2);
        chk("mrst.we_pre", 32'(rf_we), 32'd1);
        rst      = 1'b1;
        wb_valid = 1'b0;
        #1;
        chk("mrst.we", 32'(rf_we), 32'd0);
        chk("mrst.pend", 32'(ll_pending), 32'd0);
        chk("mrst.ready", 32'(ll_ready), 32'd1);
        chk("mrst.addr", 32'(rf_waddr), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst.no_stale", 32'(rf_we), 32'd0);
            chk("mrst.pend_post", 32'(ll_pending), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
